// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch buffer: default sizes and FSM states.
package instr_prefetch_pkg;

    localparam int unsigned PF_AW    = 30;
    localparam int unsigned PF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } pf_state_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Registered-storage FIFO holding {pc, instr} entries; flush empties it in one cycle.
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = PF_DEPTH,
    parameter int unsigned W     = PF_AW + 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one outstanding memory read at a time feeding a small buffer,
// with redirect flushing the buffer and discarding any in-flight response.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = PF_DEPTH,
    parameter int unsigned AW    = PF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = AW + 32;

    pf_state_t     state, state_next;
    logic [AW-1:0] fetch_pc, fetch_pc_next;
    logic [AW-1:0] addr, addr_next;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after;
    logic [EW-1:0] head;
    logic          ack, push, pop, room_after;

    assign imem_req  = (state != IDLE);
    assign imem_addr = addr;
    assign ack       = imem_req && imem_ack;
    assign pop       = (count != '0) && instr_ready && !redirect;
    assign push      = (state == REQ) && ack && !redirect;

    // Occupancy once this cycle's push and pop land; decides whether to keep fetching.
    assign occ_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    assign room_after = occ_after < (CW+1)'(DEPTH);

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end else if (count < CW'(DEPTH)) begin
                    state_next = REQ;
                    addr_next  = fetch_pc;
                end
            end
            REQ: begin
                if (ack) begin
                    if (redirect) begin
                        fetch_pc_next = redirect_pc;
                        addr_next     = redirect_pc;
                    end else begin
                        fetch_pc_next = fetch_pc + 1'b1;
                        addr_next     = fetch_pc + 1'b1;
                        if (!room_after) begin
                            state_next = IDLE;
                        end
                    end
                end else if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = DISCARD;
                end
            end
            DISCARD: begin
                // Address stays on the stale request until it completes; its data is dropped.
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end
                if (ack) begin
                    state_next = REQ;
                    addr_next  = redirect ? redirect_pc : fetch_pc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            addr     <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            addr     <= addr_next;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fetch_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign instr_valid = (count != '0);
    assign instr_pc    = head[EW-1:32];
    assign instr       = head[31:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: queue-based reference model plus directed scenarios.
module tb_instr_prefetch;

    localparam int DEPTH = 4;
    localparam int AW    = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;

    instr_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return (x * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory: acks after lat_cur waiting cycles (0 = same cycle as request); resets with the DUT.
    int lat_cfg  = 0;
    bit lat_rand = 1'b0;
    int lat_cur;
    int wcnt;

    assign imem_ack   = imem_req && (wcnt >= lat_cur);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= 0;
            lat_cur <= lat_cfg;
        end else if (imem_ack) begin
            wcnt    <= 0;
            lat_cur <= lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
        end else if (imem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    // Reference model: buffer contents as a queue, plus the one outstanding request.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   w;
    } ent_t;

    ent_t          mq[$];
    logic          m_busy, m_drop;
    logic [AW-1:0] m_addr, m_fetch;
    int            m_qs;
    bit            m_ack, m_pop;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_busy  = 1'b0;
            m_drop  = 1'b0;
            m_addr  = '0;
            m_fetch = '0;
        end else begin
            chk("imem_req", 64'(imem_req), 64'(m_busy));
            if (m_busy) chk("imem_addr", 64'(imem_addr), 64'(m_addr));
            chk("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
                chk("instr", 64'(instr), 64'(mq[0].w));
            end
            m_qs  = mq.size();
            m_ack = imem_ack && m_busy;
            m_pop = (m_qs != 0) && instr_ready;
            if (redirect) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_ack && !m_drop) mq.push_back('{pc: m_addr, w: mem_word(m_addr)});
            end
            if (!m_busy) begin
                if (redirect) m_fetch = redirect_pc;
                else if (m_qs < DEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_fetch;
                end
            end else if (m_ack) begin
                if (redirect) m_fetch = redirect_pc;
                else if (!m_drop) m_fetch = m_addr + 1'b1;
                if (redirect || m_drop || mq.size() < DEPTH) m_addr = m_fetch;
                else m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (redirect) begin
                m_fetch = redirect_pc;
                m_drop  = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int lat);
        lat_cfg  = lat;
        redirect = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] pc);
        tick();
        redirect    = 1'b1;
        redirect_pc = pc;
    endtask

    bit found;

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;

        #3;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_pc", 64'(instr_pc), 64'd0);

        // Zero-wait memory, decoder always ready: one instruction per cycle from PC 0.
        do_reset(0);
        @(negedge clk);
        @(negedge clk);
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stream_pc", 64'(instr_pc), 64'(i));
            chk("stream_word", 64'(instr), 64'(mem_word(AW'(i))));
        end

        // Decoder stalled: buffer fills to DEPTH, then drains in order and fetch resumes at 4.
        instr_ready = 1'b0;
        do_reset(0);
        repeat (12) @(negedge clk);
        chk("full_req", 64'(imem_req), 64'd0);
        chk("full_head_pc", 64'(instr_pc), 64'd0);
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_pc", 64'(instr_pc), 64'(i));
            if (i == 1) chk("drain_idle", 64'(imem_req), 64'd0);
            if (i == 2) chk("resume_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 30'd4}));
        end

        // 3-cycle memory, redirect in cycle 1 of the request for PC 5.
        do_reset(3);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (imem_req && imem_addr == AW'(5) && wcnt == 0) found = 1'b1;
        end
        chk("find_req_pc5", 64'(found), 64'd1);
        pulse_redirect(AW'('h100));
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("discard_hold", 64'({imem_req, imem_addr}), 64'({1'b1, 30'd5}));
        chk("post_redir_valid", 64'(instr_valid), 64'd0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        chk("redir_pc_0x100", 64'(instr_pc), 64'h100);
        chk("redir_word_0x100", 64'(instr), 64'(mem_word(AW'('h100))));

        // Redirect coincident with ack and pop.
        do_reset(0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == AW'(10)) found = 1'b1;
        end
        chk("steady_reached", 64'(found), 64'd1);
        pulse_redirect(AW'('h20));
        @(negedge clk);
        chk("ack_and_pop", 64'({imem_ack, instr_valid}), 64'b11);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("flush_empty", 64'(instr_valid), 64'd0);
        chk("redir_addr_0x20", 64'({imem_req, imem_addr}), 64'({1'b1, 30'h20}));
        @(negedge clk);
        chk("redir_pc_0x20", 64'(instr_pc), 64'h20);

        // PC wrap, then reset in the middle of a slow request.
        pulse_redirect(AW'('h3FFF_FFFF));
        tick();
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_top", 64'(instr_pc), 64'h3FFF_FFFF);
        @(negedge clk);
        chk("wrap_zero", 64'({instr_valid, instr_pc}), 64'({1'b1, 30'd0}));
        lat_cfg = 3;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (imem_req && wcnt == 1) found = 1'b1;
        end
        chk("mid_request", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 64'(imem_req), 64'd0);
        chk("async_rst_addr", 64'(imem_addr), 64'd0);
        chk("async_rst_valid", 64'(instr_valid), 64'd0);
        chk("async_rst_instr", 64'({instr, instr_pc}), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 30'd0}));
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        chk("restart_pc", 64'({found, instr_pc}), 64'({1'b1, 30'd0}));

        // Randomized traffic against the model.
        lat_rand = 1'b1;
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ((i % 200) < 60) instr_ready = ($urandom_range(0, 7) == 0);
            else                instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = AW'('h3FFF_FFFC) + AW'($urandom_range(0, 3));
            else                           redirect_pc = AW'($urandom);
        end
        tick();
        redirect = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
